// File: rtl/packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : packer                                                          |
// | Purpose  : Packs a stream of narrow elements into wide words. The first    |
// |            element accepted for a word lands in the LSBs. A full word is   |
// |            moved into a separate output register so accumulation of the    |
// |            next word continues while the previous one waits downstream.    |
// | Ports    : clk_i      - clock, all state on rising edge                     |
// |            reset_i    - asynchronous active-high reset                      |
// |            unpacked_i - element data        valid_i / ready_o - input hs    |
// |            packed_o   - packed word data    valid_o / ready_i - output hs   |
// |            flush_i    - emit partial word (only with PACKER_FLUSH_EN)       |
// | Config   : define PACKER_FLUSH_EN to compile in the flush_i port/logic      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module packer #(
  parameter int unpacked_width_p = 2,
  parameter int packed_num_p     = 4,
  parameter int packed_width_p   = unpacked_width_p * packed_num_p
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [unpacked_width_p-1:0] unpacked_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic [packed_width_p-1:0]   packed_o,
  output logic                        valid_o,
`ifdef PACKER_FLUSH_EN
  input  logic                        flush_i,
`endif
  input  logic                        ready_i
);

  localparam int cnt_w_lp = ($clog2(packed_num_p) > 1) ? $clog2(packed_num_p) : 1;
  localparam logic [cnt_w_lp-1:0] last_lane_lp = cnt_w_lp'(packed_num_p - 1);

  logic [cnt_w_lp-1:0]       cnt_q, cnt_d;
  logic [packed_width_p-1:0] acc_q, acc_d;
  logic [packed_width_p-1:0] packed_q, packed_d;
  logic                      valid_q, valid_d;

  logic                      at_last;
  logic                      out_free;
  logic                      flush_req;
  logic                      flush_now;
  logic                      in_fire;
  logic                      load;
  logic [packed_width_p-1:0] acc_with;

  assign at_last  = (cnt_q == last_lane_lp);
  // Output register can take a new word if empty or being drained this cycle.
  assign out_free = !valid_q || ready_i;

`ifdef PACKER_FLUSH_EN
  // flush_req feeds ready_o and so must not depend on ready_o itself; it
  // uses valid_i in place of the input fire. flush_now is the real condition
  // and only differs when ready_o is low, in which case no load happens.
  assign flush_req = flush_i && ((cnt_q != '0) || valid_i);
  assign flush_now = flush_i && ((cnt_q != '0) || in_fire);
`else
  assign flush_req = 1'b0;
  assign flush_now = 1'b0;
`endif

  // Stall only when this cycle would complete a word but the output register
  // is occupied and not draining.
  assign ready_o = !((at_last || flush_req) && !out_free);
  assign in_fire = valid_i && ready_o;

  // A completing fire always has out_free true (ready_o guarantees it); the
  // out_free term matters only for a flush without an element.
  assign load = out_free && ((in_fire && at_last) || flush_now);

  always_comb begin
    acc_with = acc_q;
    if (in_fire) begin
      acc_with[cnt_q * unpacked_width_p +: unpacked_width_p] = unpacked_i;
    end
  end

  always_comb begin
    acc_d    = acc_with;
    cnt_d    = cnt_q;
    packed_d = packed_q;
    valid_d  = valid_q;

    if (in_fire) begin
      cnt_d = cnt_q + cnt_w_lp'(1);
    end

    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    // Loading overrides the drain: valid stays high with the new word.
    if (load) begin
      packed_d = acc_with;
      valid_d  = 1'b1;
      acc_d    = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      packed_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      packed_q <= packed_d;
      valid_q  <= valid_d;
    end
  end

  assign packed_o = packed_q;
  assign valid_o  = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_packer                                                       |
// | Purpose  : Self-checking bench for packer (2-bit elements, 4 per word).    |
// |            Directed scenarios followed by a randomized handshake run       |
// |            compared against a simple packing reference model.             |
// | Config   : define PACKER_FLUSH_EN to also exercise the flush feature       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_packer;

  localparam int W  = 2;
  localparam int N  = 4;
  localparam int PW = W * N;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  din;
  logic          valid_i;
  logic          ready_o;
  logic [PW-1:0] dout;
  logic          valid_o;
  logic          ready_i;
`ifdef PACKER_FLUSH_EN
  logic          flush;
`endif

  int checks   = 0;
  int failures = 0;

  logic [PW-1:0] got_q[$];   // words leaving the DUT
  logic [W-1:0]  elem_q[$];  // elements accepted by the DUT

  always #5 clk = ~clk;

  packer #(
    .unpacked_width_p(W),
    .packed_num_p    (N)
  ) dut (
    .clk_i     (clk),
    .reset_i   (rst),
    .unpacked_i(din),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .packed_o  (dout),
    .valid_o   (valid_o),
`ifdef PACKER_FLUSH_EN
    .flush_i   (flush),
`endif
    .ready_i   (ready_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] got_at(input int idx);
    if (idx < got_q.size()) return got_q[idx];
    return 'x;
  endfunction

  // Reference packing: element k of a word occupies bits [k*W +: W].
  function automatic logic [PW-1:0] model_word(input int base);
    logic [PW-1:0] w;
    w = '0;
    for (int k = 0; k < N; k++) begin
      w = w | (PW'(elem_q[base + k]) << (k * W));
    end
    return w;
  endfunction

  // Mid-cycle monitor: record transfers that the next rising edge performs and
  // check that a stalled word is held unchanged.
  logic          prev_stall = 1'b0;
  logic [PW-1:0] prev_word  = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(valid_o), 64'd1);
        chk("hold_data", 64'(dout), 64'(prev_word));
      end
      prev_stall = valid_o && !ready_i;
      prev_word  = dout;
      if (valid_o && ready_i) got_q.push_back(dout);
      if (valid_i && ready_o) elem_q.push_back(din);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    valid_i = 1'b1;
    din     = d;
    #1;
    chk("ready_stream", 64'(ready_o), 64'd1);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int nwords;

    rst     = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    din     = '0;
`ifdef PACKER_FLUSH_EN
    flush   = 1'b0;
`endif
    tick(); tick(); tick();
    chk("reset_valid", 64'(valid_o), 64'd0);
    chk("reset_data", 64'(dout), 64'h0);
    rst = 1'b0;
    #1;
    chk("reset_ready", 64'(ready_o), 64'd1);

    // Single word 1,2,3,0 -> 8'h39 valid for exactly one cycle.
    got_q.delete();
    send(2'd1); send(2'd2); send(2'd3); send(2'd0);
    valid_i = 1'b0;
    #1;
    chk("w1_valid", 64'(valid_o), 64'd1);
    chk("w1_data", 64'(dout), 64'h39);
    tick();
    chk("w1_valid_drop", 64'(valid_o), 64'd0);
    chk("w1_count", 64'(got_q.size()), 64'd1);
    chk("w1_word", 64'(got_at(0)), 64'h39);

    // Back-to-back two words, no stall.
    got_q.delete();
    send(2'd1); send(2'd2); send(2'd3); send(2'd0);
    send(2'd3); send(2'd3); send(2'd3); send(2'd3);
    valid_i = 1'b0;
    tick(); tick();
    chk("b2b_count", 64'(got_q.size()), 64'd2);
    chk("b2b_word0", 64'(got_at(0)), 64'h39);
    chk("b2b_word1", 64'(got_at(1)), 64'hFF);

    // Backpressure: output occupied while the next word completes.
    got_q.delete();
    send(2'd1); send(2'd2); send(2'd3); send(2'd0);
    ready_i = 1'b0;
    send(2'd3); send(2'd3); send(2'd3);
    valid_i = 1'b1;
    din     = 2'd3;
    #1;
    chk("stall_ready", 64'(ready_o), 64'd0);
    tick();
    chk("stall_ready2", 64'(ready_o), 64'd0);
    chk("stall_valid", 64'(valid_o), 64'd1);
    chk("stall_data", 64'(dout), 64'h39);
    ready_i = 1'b1;
    #1;
    chk("ready_rise", 64'(ready_o), 64'd1);
    tick();
    valid_i = 1'b0;
    #1;
    chk("swap_valid", 64'(valid_o), 64'd1);
    chk("swap_data", 64'(dout), 64'hFF);
    tick();
    chk("swap_drain", 64'(valid_o), 64'd0);
    chk("bp_count", 64'(got_q.size()), 64'd2);
    chk("bp_word0", 64'(got_at(0)), 64'h39);
    chk("bp_word1", 64'(got_at(1)), 64'hFF);

    // Reset in the middle of a word discards the partial word.
    got_q.delete();
    send(2'd1); send(2'd1);
    valid_i = 1'b0;
    rst     = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(valid_o), 64'd0);
    tick();
    chk("rst_mid_valid2", 64'(valid_o), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_ready", 64'(ready_o), 64'd1);
    send(2'd0); send(2'd1); send(2'd2); send(2'd3);
    valid_i = 1'b0;
    tick(); tick();
    chk("rst_count", 64'(got_q.size()), 64'd1);
    chk("rst_word", 64'(got_at(0)), 64'hE4);

`ifdef PACKER_FLUSH_EN
    // Partial word via flush, empty flush, flush together with first element.
    got_q.delete();
    send(2'd3); send(2'd1);
    valid_i = 1'b0;
    flush   = 1'b1;
    #1;
    chk("flush_ready", 64'(ready_o), 64'd1);
    tick();
    flush = 1'b0;
    chk("flush_valid", 64'(valid_o), 64'd1);
    chk("flush_data", 64'(dout), 64'h07);
    tick();
    chk("flush_drain", 64'(valid_o), 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_empty", 64'(valid_o), 64'd0);
    flush   = 1'b1;
    valid_i = 1'b1;
    din     = 2'd2;
    tick();
    flush   = 1'b0;
    valid_i = 1'b0;
    chk("flush_one_valid", 64'(valid_o), 64'd1);
    chk("flush_one_data", 64'(dout), 64'h02);
    send(2'd1); send(2'd2); send(2'd3); send(2'd0);
    valid_i = 1'b0;
    tick(); tick();
    chk("flush_count", 64'(got_q.size()), 64'd3);
    chk("flush_word0", 64'(got_at(0)), 64'h07);
    chk("flush_word1", 64'(got_at(1)), 64'h02);
    chk("flush_word2", 64'(got_at(2)), 64'h39);
`endif

    // Random handshakes on both sides against the reference model.
    got_q.delete();
    elem_q.delete();
    cycles = 0;
    while (elem_q.size() < 1000 && cycles < 20000) begin
      valid_i = 1'($urandom_range(0, 1));
      din     = 2'($urandom);
      ready_i = 1'($urandom_range(0, 1));
      #1;
      chk("rand_ready", 64'(ready_o),
          64'(!(((elem_q.size() % N) == N - 1) && valid_o && !ready_i)));
      tick();
      cycles++;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick(); tick(); tick();
    chk("rand_budget", 64'(cycles < 20000), 64'd1);
    chk("rand_elems", 64'(elem_q.size()), 64'd1000);
    nwords = elem_q.size() / N;
    chk("rand_words", 64'(got_q.size()), 64'(nwords));
    for (int i = 0; i < nwords; i++) begin
      chk("rand_word", 64'(got_at(i)), 64'(model_word(i * N)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/packer.md
PACKER -- requirements
Module: packer

Interface
REQ-001 SHALL have parameter unpacked_width_p, default 2: width of one input element.
REQ-002 SHALL have parameter packed_num_p, default 4: elements per packed word; must be >= 2.
REQ-003 SHALL have parameter packed_width_p, default unpacked_width_p*packed_num_p: output word width.
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port unpacked_i  input  unpacked_width_p  element data.
REQ-007 SHALL have port valid_i  input  1  element valid.
REQ-008 SHALL have port ready_o  output  1  element accepted when valid_i && ready_o.
REQ-009 SHALL have port packed_o  output  packed_width_p  packed word data.
REQ-010 SHALL have port valid_o  output  1  packed word valid.
REQ-011 SHALL have port ready_i  input  1  word consumed when valid_o && ready_i.
REQ-012 SHALL have port flush_i  input  1  emit partial word; present only when PACKER_FLUSH_EN is defined.

Function
REQ-013 SHALL hold an accumulator register, a lane counter (0..packed_num_p-1) and a separate output register with a valid flag.
REQ-014 SHALL write the k-th accepted element of a word into bits [k*unpacked_width_p +: unpacked_width_p]; the first element goes to the LSBs.
REQ-015 SHALL increment the lane counter on every input fire and wrap it from packed_num_p-1 to 0.
REQ-016 SHALL, on the input fire that fills lane packed_num_p-1, load the full word (accumulator plus the current element) into the output register and set valid_o on the next edge; latency from last element to valid_o is 1 cycle.
REQ-017 SHALL clear the accumulator to zero whenever a word is transferred to the output register.
REQ-018 SHALL hold packed_o and valid_o stable while valid_o=1 and ready_i=0.
REQ-019 SHALL clear valid_o on an output fire unless a new word is loaded on the same edge, in which case valid_o stays 1 with the new data.
REQ-020 SHALL drive ready_o combinationally as NOT(counter==packed_num_p-1 AND valid_o AND NOT ready_i); it stalls only when completing a word while the output register is occupied and not draining.
REQ-021 SHALL sustain one element per cycle, i.e. one word per packed_num_p cycles, with ready_i held at 1.
REQ-022 SHALL ignore unpacked_i when there is no input fire; the accumulator and counter SHALL stay unchanged.
REQ-023 SHALL size the counter as max(1,$clog2(packed_num_p)) bits and SHALL compare it against packed_num_p-1 truncated to that width.

Reset
REQ-024 SHALL, on reset_i assertion, asynchronously clear the counter, accumulator, output register and valid_o to 0, at any point in a word.
REQ-025 SHALL discard any partial word on reset; ready_o SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-026 SHALL compile the flush feature in only when the macro PACKER_FLUSH_EN is defined.
REQ-027 With PACKER_FLUSH_EN defined and flush_i=1 and counter>0 (counting any element firing that cycle), the block SHALL move the accumulator to the output register with the unfilled upper lanes zero and reset the counter to 0; stall and ready_o rules SHALL match REQ-020, with "completing a word" extended to include the flush condition.
REQ-028 With PACKER_FLUSH_EN defined, flush_i with counter==0 and no element firing SHALL have no effect, and no empty word SHALL ever be emitted.
REQ-029 With PACKER_FLUSH_EN undefined, the flush_i port and its logic SHALL be absent, and words SHALL be emitted only when full.

Verification (unpacked_width_p=2, packed_num_p=4)
REQ-030 Elements 1,2,3,0 on consecutive cycles with ready_i=1 -> valid_o=1 one cycle after the 4th fire, with packed_o=8'h39 for exactly 1 cycle.
REQ-031 8 back-to-back elements 1,2,3,0,3,3,3,3 with ready_i=1 -> ready_o stays 1 throughout and the words are 8'h39 then 8'hFF.
REQ-032 Hold ready_i=0 after the first word, then send 4 more elements -> ready_o drops on the 4th element, 8'h39 is held, and ready_o rises in the cycle ready_i=1.
REQ-033 Send 2 elements, assert reset_i mid-word, then send 0,1,2,3 -> the only word seen is 8'hE4; valid_o is 0 throughout reset.
REQ-034 With PACKER_FLUSH_EN defined, send 3 then 1 then pulse flush_i -> packed_o=8'h07 and valid_o=1; the next 4 elements form an aligned full word.
REQ-035 Run random valid_i/ready_i at 50% over 1000 elements -> the output stream equals a reference packing model with no loss or duplication.
